uart_tx: RTL and testbench

//   UART serialiser that sits downstream of the mod-M baud tick counter. Its max_tick output

---
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART frame serialiser: start bit, DBIT data bits LSB first, optional parity, stop bit(s).
// Paced by a 16x-baud s_tick; the line output is registered and idles high.
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [5:0]    S_LAST    = 6'd15;
    localparam logic [5:0]    STOP_LAST = 6'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    // Parity comes from the word captured at accept, never from the shifting copy.
    function automatic logic parity_bit(input logic [DBIT-1:0] w);
        return (^w) ^ (PARITY_ODD != 0);
    endfunction

    logic [2:0]      state_q, state_d;
    logic [5:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dl_q, dl_d;
    logic            tx_q, tx_d;
    logic            done;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dl_d    = dl_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                // A tick coinciding with accept is deliberately not counted.
                if (tx_start) begin
                    b_d     = din;
                    dl_d    = din;
                    s_d     = 6'd0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = 6'd0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = 6'd0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = 6'd0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = 6'd0;
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 6'd0;
                n_d     = '0;
            end
        endcase
    end

    // Line value follows the next state so tx moves on the same edge as the FSM.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = parity_bit(dl_q);
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 6'd0;
            n_q     <= '0;
            b_q     <= '0;
            dl_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dl_q    <= dl_d;
            tx_q    <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five parameterisations share clk, reset and s_tick (one tick every 4 clk);
// frames are checked bit by bit at every tick against hand-computed bit patterns.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] din_r = 8'h00;
    logic [4:0] start_r = 5'b0;
    logic [4:0] tx_w, busy_w, done_w;
    int         tdiv = 0;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tdiv   = (tdiv == 3) ? 0 : tdiv + 1;
        s_tick = (tdiv == 3);
    end

    uart_tx u0 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_r[0]), .din(din_r),
                .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .reset(reset), .s_tick(s_tick),
                .tx_start(start_r[1]), .din(din_r),
                .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .reset(reset), .s_tick(s_tick),
                .tx_start(start_r[2]), .din(din_r),
                .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));
    uart_tx #(.SB_TICK(32)) u3 (.clk(clk), .reset(reset), .s_tick(s_tick),
                .tx_start(start_r[3]), .din(din_r),
                .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]));
    uart_tx #(.DBIT(7)) u4 (.clk(clk), .reset(reset), .s_tick(s_tick),
                .tx_start(start_r[4]), .din(din_r[6:0]),
                .tx(tx_w[4]), .tx_busy(busy_w[4]), .tx_done_tick(done_w[4]));

    typedef struct {
        int         dut;
        logic [7:0] din;
        int         nb;      // bits between start and stop (data + parity)
        logic [9:0] bits;    // expected serial bits after the start bit, first-sent in bit 0
        int         ticks;   // accept-to-done length in ticks
        int         inj;     // tick at which a stray tx_start with din=0 is injected (0 = none)
        string      name;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_frame(input int k, input logic [7:0] d, input string nm, output int waited);
        waited = 0;
        @(posedge clk); #1;
        while (busy_w[k] && waited < 4000) begin
            @(posedge clk); #1;
            waited++;
        end
        check({nm, " idle busy"}, 32'(busy_w[k]), 32'd0);
        check({nm, " idle tx"}, 32'(tx_w[k]), 32'd1);
        din_r = d;
        start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
        check({nm, " accept tx"}, 32'(tx_w[k]), 32'd0);
        check({nm, " accept busy"}, 32'(busy_w[k]), 32'd1);
    endtask

    // Returns on the negedge of the done tick (or at tick 'abort' if nonzero).
    task automatic monitor(input int k, input int nb, input logic [9:0] bits, input int ticks,
                           input int inj, input int abort, input string nm);
        int   i = 0;
        int   cyc = 0;
        int   busyerr = 0;
        int   errs[12];
        logic lastv[12];
        logic injd = 1'b0;
        for (int p = 0; p < 12; p++) begin
            errs[p]  = 0;
            lastv[p] = 1'b0;
        end
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (injd) begin
                start_r[k] = 1'b0;
                injd = 1'b0;
            end
            if (s_tick) begin
                int   pos;
                logic e;
                i++;
                pos = (i - 1) / 16;
                if (pos > nb + 1) pos = nb + 1;
                e = (pos == 0) ? 1'b0 : (pos <= nb) ? bits[pos-1] : 1'b1;
                if (tx_w[k] !== e) begin
                    errs[pos]++;
                    lastv[pos] = tx_w[k];
                end
                if (busy_w[k] !== 1'b1) busyerr++;
                if (abort != 0 && i == abort) return;
                if (done_w[k]) break;
                if (inj != 0 && i == inj) begin
                    start_r[k] = 1'b1;
                    din_r = 8'h00;
                    injd = 1'b1;
                end
            end else if (done_w[k]) begin
                busyerr++;
            end
        end
        for (int p = 0; p <= nb + 1; p++) begin
            logic e;
            e = (p == 0) ? 1'b0 : (p <= nb) ? bits[p-1] : 1'b1;
            check($sformatf("%s bit%0d", nm, p), 32'((errs[p] != 0) ? lastv[p] : e), 32'(e));
        end
        check({nm, " busy held"}, 32'(busyerr), 32'd0);
        check({nm, " done tick"}, 32'(i), 32'(ticks));
    endtask

    vec_t vecs[7];
    int   w;

    initial begin
        vecs[0] = '{0, 8'h55, 8, 10'h055, 160, 0,  "d55"};
        vecs[1] = '{1, 8'hA3, 9, 10'h0A3, 176, 0,  "parE_A3"};
        vecs[2] = '{2, 8'hA3, 9, 10'h1A3, 176, 0,  "parO_A3"};
        vecs[3] = '{1, 8'hA1, 9, 10'h1A1, 176, 40, "parE_A1_inj"};
        vecs[4] = '{3, 8'h55, 8, 10'h055, 176, 0,  "sb32"};
        vecs[5] = '{4, 8'h7F, 7, 10'h07F, 144, 0,  "dbit7"};
        vecs[6] = '{0, 8'hA3, 8, 10'h0A3, 160, 50, "midstart"};

        // Reset state of every instance
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst tx%0d", k), 32'(tx_w[k]), 32'd1);
            check($sformatf("rst busy%0d", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("rst done%0d", k), 32'(done_w[k]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of DATA aborts immediately
        start_frame(0, 8'h55, "abort", w);
        monitor(0, 8, 10'h055, 160, 0, 40, "abort");
        reset = 1'b1;
        #1;
        check("abort tx", 32'(tx_w[0]), 32'd1);
        check("abort busy", 32'(busy_w[0]), 32'd0);
        check("abort done", 32'(done_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start_frame(0, 8'hC6, "post_rst", w);
        monitor(0, 8, 10'h0C6, 160, 0, 0, "post_rst");

        for (int v = 0; v < 7; v++) begin
            start_frame(vecs[v].dut, vecs[v].din, vecs[v].name, w);
            monitor(vecs[v].dut, vecs[v].nb, vecs[v].bits, vecs[v].ticks, vecs[v].inj, 0, vecs[v].name);
        end

        // Request on the done clk is dropped; request on the following clk is taken
        start_frame(0, 8'h3C, "dropA", w);
        monitor(0, 8, 10'h03C, 160, 0, 0, "dropA");
        start_r[0] = 1'b1;
        din_r = 8'h0F;
        @(posedge clk); #1;
        check("drop busy", 32'(busy_w[0]), 32'd0);
        check("drop tx", 32'(tx_w[0]), 32'd1);
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        check("next tx", 32'(tx_w[0]), 32'd0);
        check("next busy", 32'(busy_w[0]), 32'd1);
        monitor(0, 8, 10'h00F, 160, 0, 0, "dropB");

        // Back-to-back frames abut with a single clk of idle
        start_frame(0, 8'hFF, "b2bA", w);
        monitor(0, 8, 10'h0FF, 160, 0, 0, "b2bA");
        start_frame(0, 8'h00, "b2bB", w);
        check("b2b idle wait", 32'(w), 32'd0);
        monitor(0, 8, 10'h000, 160, 0, 0, "b2bB");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
